// File: rtl/spi_fetch_arbiter.sv
// Arbitrates video/audio fetch requests onto one SPI slave: sends the command byte,
// waits for the echoed header, then streams the payload into the owner's buffer.
module spi_fetch_arbiter #(
    parameter logic [7:0] VIDEO_CMD   = 8'hFA,
    parameter logic [7:0] AUDIO_CMD   = 8'hAA,
    parameter int         HDR_TIMEOUT = 1024,
    parameter int         LEN_W       = 16
) (
    input  logic             CLK_40,
    input  logic             reset,
    input  logic             SPI_clk_en,
    input  logic             req_video,
    input  logic             req_audio,
    input  logic [LEN_W-1:0] len_video,
    input  logic [LEN_W-1:0] len_audio,
    input  logic             audio_urgent,
    output logic             cmd_valid,
    output logic [7:0]       cmd_byte,
    input  logic             cmd_ready,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             chip_select,
    output logic             grant_video,
    output logic             grant_audio,
    output logic             wr_en_video,
    output logic             wr_en_audio,
    output logic [7:0]       wr_data,
    output logic             xfer_done,
    output logic             hdr_err,
    output logic             busy
);

    localparam int TO_W = (HDR_TIMEOUT > 1) ? $clog2(HDR_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(HDR_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_HDR,
        STREAM,
        DONE,
        GAP
    } state_t;

    state_t state, state_next;

    // owner / last_owner: 0 = video, 1 = audio
    logic             owner;
    logic             last_owner;
    logic [LEN_W-1:0] remaining;
    logic [TO_W-1:0]  hdr_cnt;

    logic pick_audio;
    logic grant_fire;
    logic hdr_match;
    logic hdr_abort;
    logic byte_fire;
    logic done_fire;

    // Urgent audio beats everything; a tie alternates away from the last completed owner.
    always_comb begin
        if (req_audio && audio_urgent) begin
            pick_audio = 1'b1;
        end else if (req_audio && req_video) begin
            pick_audio = ~last_owner;
        end else begin
            pick_audio = req_audio;
        end
    end

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant_fire  = 1'b0;
        hdr_match   = 1'b0;
        hdr_abort   = 1'b0;
        byte_fire   = 1'b0;
        done_fire   = 1'b0;
        cmd_valid   = (state == SEND_CMD);
        chip_select = (state == IDLE) || (state == GAP);
        busy        = (state != IDLE);
        grant_video = (state != IDLE) && !owner;
        grant_audio = (state != IDLE) && owner;

        if (SPI_clk_en) begin
            case (state)
                IDLE: begin
                    if (req_video || req_audio) begin
                        grant_fire = 1'b1;
                        state_next = SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (cmd_ready) begin
                        state_next = WAIT_HDR;
                    end
                end
                WAIT_HDR: begin
                    if (rx_valid && (rx_data == cmd_byte)) begin
                        hdr_match  = 1'b1;
                        state_next = (remaining == '0) ? DONE : STREAM;
                    end else if (hdr_cnt == TO_LAST) begin
                        hdr_abort  = 1'b1;
                        state_next = GAP;
                    end
                end
                STREAM: begin
                    if (rx_valid) begin
                        byte_fire = 1'b1;
                        if (remaining <= LEN_W'(1)) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    done_fire  = 1'b1;
                    state_next = GAP;
                end
                GAP: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            remaining   <= '0;
            hdr_cnt     <= '0;
            cmd_byte    <= 8'h00;
            wr_en_video <= 1'b0;
            wr_en_audio <= 1'b0;
            wr_data     <= 8'h00;
            xfer_done   <= 1'b0;
            hdr_err     <= 1'b0;
        end else begin
            wr_en_video <= 1'b0;
            wr_en_audio <= 1'b0;
            xfer_done   <= done_fire;
            hdr_err     <= hdr_abort;

            if (grant_fire) begin
                owner     <= pick_audio;
                remaining <= pick_audio ? len_audio : len_video;
                cmd_byte  <= pick_audio ? AUDIO_CMD : VIDEO_CMD;
                hdr_cnt   <= '0;
            end

            if (SPI_clk_en && (state == WAIT_HDR) && !hdr_match) begin
                hdr_cnt <= hdr_cnt + TO_W'(1);
            end

            if (byte_fire) begin
                wr_en_video <= !owner;
                wr_en_audio <= owner;
                wr_data     <= rx_data;
                if (remaining != '0) begin
                    remaining <= remaining - LEN_W'(1);
                end
            end

            // An aborted transfer leaves last_owner alone so the same requester retries.
            if (done_fire) begin
                last_owner <= owner;
            end
        end
    end

endmodule

// File: tb/tb_spi_fetch_arbiter.sv
// Bench for spi_fetch_arbiter: cycle vectors, directed corner sequences and
// randomized transfers scored against a transaction-level model.
module tb_spi_fetch_arbiter;

    localparam int         HDR_T = 8;
    localparam logic [7:0] VCMD  = 8'hFA;
    localparam logic [7:0] ACMD  = 8'hAA;

    logic        CLK_40 = 1'b0;
    logic        reset;
    logic        SPI_clk_en;
    logic        req_video;
    logic        req_audio;
    logic [15:0] len_video;
    logic [15:0] len_audio;
    logic        audio_urgent;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        cmd_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        chip_select;
    logic        grant_video;
    logic        grant_audio;
    logic        wr_en_video;
    logic        wr_en_audio;
    logic [7:0]  wr_data;
    logic        xfer_done;
    logic        hdr_err;
    logic        busy;

    spi_fetch_arbiter #(
        .VIDEO_CMD  (VCMD),
        .AUDIO_CMD  (ACMD),
        .HDR_TIMEOUT(HDR_T),
        .LEN_W      (16)
    ) dut (
        .CLK_40      (CLK_40),
        .reset       (reset),
        .SPI_clk_en  (SPI_clk_en),
        .req_video   (req_video),
        .req_audio   (req_audio),
        .len_video   (len_video),
        .len_audio   (len_audio),
        .audio_urgent(audio_urgent),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .cmd_ready   (cmd_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .chip_select (chip_select),
        .grant_video (grant_video),
        .grant_audio (grant_audio),
        .wr_en_video (wr_en_video),
        .wr_en_audio (wr_en_audio),
        .wr_data     (wr_data),
        .xfer_done   (xfer_done),
        .hdr_err     (hdr_err),
        .busy        (busy)
    );

    always #5 CLK_40 = ~CLK_40;

    int checks = 0;
    int errors = 0;

    // Monitor: every buffer write as {owner, byte}, plus pulse and exclusivity counts.
    logic [8:0] wr_q[$];
    int xd_cnt   = 0;
    int he_cnt   = 0;
    int both_cnt = 0;
    logic model_last;

    always @(negedge CLK_40) begin
        if (reset === 1'b0) begin
            if (wr_en_video) wr_q.push_back({1'b0, wr_data});
            if (wr_en_audio) wr_q.push_back({1'b1, wr_data});
            if (xfer_done) xd_cnt++;
            if (hdr_err) he_cnt++;
            if (grant_video && grant_audio) both_cnt++;
            if (wr_en_video && wr_en_audio) both_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [24:0] pk(input logic cs, input logic cv, input logic [7:0] cb,
                                       input logic gv, input logic ga, input logic wv,
                                       input logic wa, input logic [7:0] wd, input logic xd,
                                       input logic he, input logic bsy);
        return {cs, cv, cb, gv, ga, wv, wa, wd, xd, he, bsy};
    endfunction

    function automatic logic [24:0] outs();
        return {chip_select, cmd_valid, cmd_byte, grant_video, grant_audio,
                wr_en_video, wr_en_audio, wr_data, xfer_done, hdr_err, busy};
    endfunction

    function automatic logic [7:0] noncmd(input logic [7:0] c);
        logic [7:0] r;
        r = 8'($urandom);
        if (r == c) r = r ^ 8'h01;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic rxv, input logic [7:0] rxd);
        SPI_clk_en = en;
        rx_valid   = rxv;
        rx_data    = rxd;
        @(posedge CLK_40);
        #1;
        SPI_clk_en = 1'b0;
        rx_valid   = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        SPI_clk_en   = 1'b0;
        req_video    = 1'b0;
        req_audio    = 1'b0;
        audio_urgent = 1'b0;
        cmd_ready    = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        repeat (2) @(posedge CLK_40);
        #1 reset = 1'b0;
        #1;
        model_last = 1'b1;
    endtask

    // One complete transaction driven as the SPI slave; the model predicts the owner from
    // the requests at grant time and the exact write list / pulse counts from the bytes sent.
    task automatic do_xfer(input logic rv, input logic ra, input logic urg,
                           input logic [15:0] lv, input logic [15:0] la, input int ngarb,
                           input logic tmo, input logic gaps, output logic own);
        logic       exp_own;
        logic [7:0] cmd;
        logic [7:0] d;
        logic [15:0] len;
        logic [8:0] exp_q[$];
        int base_w, base_x, base_h, n;

        if (ra && urg) exp_own = 1'b1;
        else if (ra && rv) exp_own = !model_last;
        else exp_own = ra;
        cmd = exp_own ? ACMD : VCMD;
        len = exp_own ? la : lv;
        base_w = wr_q.size();
        base_x = xd_cnt;
        base_h = he_cnt;

        req_video = rv; req_audio = ra; audio_urgent = urg;
        len_video = lv; len_audio = la; cmd_ready = 1'b0;
        n = 0;
        do begin
            cyc(gaps ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 8'h00);
            n++;
        end while (!cmd_valid && n < 20);
        chk("grant_owner", {grant_audio, grant_video}, exp_own ? 2'b10 : 2'b01);
        chk("cmd_byte", cmd_byte, cmd);
        own = grant_audio;

        req_video = 1'($urandom); req_audio = 1'($urandom); audio_urgent = 1'($urandom);
        len_video = 16'($urandom); len_audio = 16'($urandom);

        repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b0, 8'h00);
        cmd_ready = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        chk("cmd_hold", cmd_valid, 1);
        cyc(1'b1, 1'b0, 8'h00);
        cmd_ready = 1'b0;
        chk("cmd_drop", {cmd_valid, chip_select}, 2'b00);

        if (tmo) begin
            for (int t = 1; t <= HDR_T; t++) begin
                if (gaps && $urandom_range(0, 2) == 0) cyc(1'b0, 1'b1, cmd);
                cyc(1'b1, 1'($urandom), noncmd(cmd));
                if (t == HDR_T - 1) chk("hdr_wait", {chip_select, hdr_err}, 2'b00);
            end
            chk("hdr_abort", {chip_select, hdr_err}, 2'b11);
        end else begin
            for (int g = 0; g < ngarb; g++) cyc(1'b1, 1'b1, noncmd(cmd));
            if (gaps) cyc(1'b0, 1'b1, cmd);
            cyc(1'b1, 1'b1, cmd);
            for (int b = 0; b < int'(len); b++) begin
                d = 8'($urandom);
                if (gaps && $urandom_range(0, 2) == 0) cyc(1'b0, 1'b1, ~d);
                if ($urandom_range(0, 3) == 0) cyc(1'b1, 1'b0, 8'h00);
                cyc(1'b1, 1'b1, d);
                exp_q.push_back({exp_own, d});
            end
        end

        n = 0;
        while (busy && n < 10) begin
            cyc(1'b1, 1'b1, 8'($urandom));
            n++;
        end
        chk("back_to_idle", {busy, chip_select}, 2'b01);
        @(negedge CLK_40);
        #1;
        chk("n_writes", wr_q.size() - base_w, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_w + i < wr_q.size()) chk("wr_byte", wr_q[base_w + i], exp_q[i]);
        end
        chk("xfer_done_cnt", xd_cnt - base_x, tmo ? 0 : 1);
        chk("hdr_err_cnt", he_cnt - base_h, tmo ? 1 : 0);
        if (!tmo) model_last = exp_own;
        req_video = 1'b0; req_audio = 1'b0; audio_urgent = 1'b0;
    endtask

    typedef struct {
        logic        en, rv, crdy, rxv;
        logic [7:0]  rxd;
        logic [15:0] lv;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[14];
    logic own;
    logic rv_r, ra_r;
    int bw, bx;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd3, pk(1'b0,1'b1,VCMD,1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1)};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd9, pk(1'b0,1'b1,VCMD,1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1)};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd9, pk(1'b0,1'b0,VCMD,1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1)};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd9, pk(1'b0,1'b0,VCMD,1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1)};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hFA, 16'd9, pk(1'b0,1'b0,VCMD,1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1)};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 16'd9, pk(1'b0,1'b0,VCMD,1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1)};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 16'd9, pk(1'b0,1'b0,VCMD,1'b1,1'b0,1'b1,1'b0,8'h11,1'b0,1'b0,1'b1)};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd9, pk(1'b0,1'b0,VCMD,1'b1,1'b0,1'b0,1'b0,8'h11,1'b0,1'b0,1'b1)};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 16'd9, pk(1'b0,1'b0,VCMD,1'b1,1'b0,1'b1,1'b0,8'h22,1'b0,1'b0,1'b1)};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 16'd9, pk(1'b0,1'b0,VCMD,1'b1,1'b0,1'b1,1'b0,8'h33,1'b0,1'b0,1'b1)};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 16'd9, pk(1'b1,1'b0,VCMD,1'b1,1'b0,1'b0,1'b0,8'h33,1'b1,1'b0,1'b1)};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd9, pk(1'b1,1'b0,VCMD,1'b1,1'b0,1'b0,1'b0,8'h33,1'b0,1'b0,1'b1)};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd9, pk(1'b1,1'b0,VCMD,1'b0,1'b0,1'b0,1'b0,8'h33,1'b0,1'b0,1'b0)};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd9, pk(1'b1,1'b0,VCMD,1'b0,1'b0,1'b0,1'b0,8'h33,1'b0,1'b0,1'b0)};

        len_video = 16'd0;
        len_audio = 16'd0;
        do_reset();
        chk("reset_state", outs(), pk(1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0));

        // Video-only transfer of three bytes, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            req_video = tbl[i].rv;
            len_video = tbl[i].lv;
            cmd_ready = tbl[i].crdy;
            cyc(tbl[i].en, tbl[i].rxv, tbl[i].rxd);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        req_video = 1'b0;
        cmd_ready = 1'b0;

        // Round robin from reset, then urgent audio overriding the rotation.
        do_reset();
        do_xfer(1'b1, 1'b1, 1'b0, 16'd2, 16'd2, 1, 1'b0, 1'b0, own);
        chk("rr_first_video", own, 0);
        do_xfer(1'b1, 1'b1, 1'b0, 16'd2, 16'd2, 0, 1'b0, 1'b0, own);
        chk("rr_second_audio", own, 1);
        do_xfer(1'b1, 1'b1, 1'b1, 16'd1, 16'd1, 0, 1'b0, 1'b0, own);
        chk("urgent_audio", own, 1);

        // Header timeout does not advance the rotation.
        do_reset();
        do_xfer(1'b1, 1'b1, 1'b0, 16'd3, 16'd3, 0, 1'b1, 1'b0, own);
        chk("tmo_owner", own, 0);
        do_xfer(1'b1, 1'b1, 1'b0, 16'd3, 16'd3, 0, 1'b0, 1'b0, own);
        chk("tmo_regrant", own, 0);

        // Zero-length audio fetch.
        do_xfer(1'b0, 1'b1, 1'b0, 16'd5, 16'd0, 2, 1'b0, 1'b0, own);
        chk("len0_owner", own, 1);

        // Reset in the middle of a four-byte audio transfer.
        do_reset();
        bw = wr_q.size();
        bx = xd_cnt;
        req_audio = 1'b1; len_audio = 16'd4;
        cyc(1'b1, 1'b0, 8'h00);
        req_audio = 1'b0; cmd_ready = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        cmd_ready = 1'b0;
        cyc(1'b1, 1'b1, ACMD);
        cyc(1'b1, 1'b1, 8'hC1);
        cyc(1'b1, 1'b1, 8'hC2);
        cyc(1'b0, 1'b0, 8'h00);
        #2 reset = 1'b1;
        #1 chk("rst_async", outs(), pk(1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0));
        cyc(1'b1, 1'b1, 8'hC3);
        reset = 1'b0;
        model_last = 1'b1;
        cyc(1'b1, 1'b1, 8'hC3);
        cyc(1'b1, 1'b1, 8'hC4);
        cyc(1'b1, 1'b0, 8'h00);
        @(negedge CLK_40);
        #1;
        chk("rst_writes", wr_q.size() - bw, 2);
        if (wr_q.size() - bw >= 2) begin
            chk("rst_byte0", wr_q[bw], {1'b1, 8'hC1});
            chk("rst_byte1", wr_q[bw + 1], {1'b1, 8'hC2});
        end
        chk("rst_no_done", xd_cnt - bx, 0);
        chk("rst_idle", {busy, chip_select}, 2'b01);

        // Enable held low for five cycles mid-stream.
        do_reset();
        bw = wr_q.size();
        bx = xd_cnt;
        req_video = 1'b1; len_video = 16'd3;
        cyc(1'b1, 1'b0, 8'h00);
        req_video = 1'b0; cmd_ready = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        cmd_ready = 1'b0;
        cyc(1'b1, 1'b1, VCMD);
        cyc(1'b1, 1'b1, 8'h5A);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 8'(8'hE0 + k));
            chk($sformatf("stall%0d", k), outs(), pk(1'b0,1'b0,VCMD,1'b1,1'b0,1'b0,1'b0,8'h5A,1'b0,1'b0,1'b1));
        end
        cyc(1'b1, 1'b1, 8'h6B);
        cyc(1'b1, 1'b1, 8'h7C);
        chk("stall_last", outs(), pk(1'b0,1'b0,VCMD,1'b1,1'b0,1'b1,1'b0,8'h7C,1'b0,1'b0,1'b1));
        cyc(1'b1, 1'b0, 8'h00);
        chk("stall_done", {xfer_done, chip_select}, 2'b11);
        cyc(1'b1, 1'b0, 8'h00);
        @(negedge CLK_40);
        #1;
        chk("stall_writes", wr_q.size() - bw, 3);
        chk("stall_done_cnt", xd_cnt - bx, 1);

        // Randomized transfers against the model.
        do_reset();
        repeat (40) begin
            rv_r = 1'($urandom);
            ra_r = 1'($urandom);
            if (!rv_r && !ra_r) rv_r = 1'b1;
            do_xfer(rv_r, ra_r, 1'($urandom), 16'($urandom_range(0, 5)),
                    16'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                    ($urandom_range(0, 5) == 0), 1'b1, own);
        end

        chk("grant_exclusive", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_fetch_arbiter.md
SPI_FETCH_ARBITER -- requirements
Module: spi_fetch_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  VIDEO_CMD  8'hFA  command byte for the video fetch; also the expected header byte
  AUDIO_CMD  8'hAA  command byte for the audio fetch; also the expected header byte
  HDR_TIMEOUT  1024  SPI ticks allowed in WAIT_HDR before abort
  LEN_W  16  width of the transfer length
REQ-002 Ports, one per line (name, direction, width, meaning):
  CLK_40  in  1  sole clock
  reset  in  1  asynchronous, active-high
  SPI_clk_en  in  1  SPI tick; state advances only on CLK_40 edges where this is 1
  req_video / req_audio  in  1  fetch requests, level
  len_video / len_audio  in  LEN_W  payload byte count for each requester
  audio_urgent  in  1  audio buffer below low-water mark
  cmd_valid  out  1  command byte offered to the SPI master
  cmd_byte  out  8  command byte
  cmd_ready  in  1  SPI master accepted the command
  rx_valid  in  1  received byte strobe, qualified by SPI_clk_en
  rx_data  in  8  received byte
  chip_select  out  1  slave select, active-low
  grant_video / grant_audio  out  1  one-hot current owner
  wr_en_video / wr_en_audio  out  1  buffer write strobes
  wr_data  out  8  byte to write
  xfer_done  out  1  one-cycle pulse when a transfer completes
  hdr_err  out  1  one-cycle pulse on header timeout
  busy  out  1  state != IDLE

Function
REQ-003 The FSM SHALL have the states IDLE, SEND_CMD, WAIT_HDR, STREAM, DONE, GAP, and all transitions SHALL occur only on ticks where SPI_clk_en=1.
REQ-004 In IDLE with any request asserted, the block SHALL grant on that tick and go to SEND_CMD; it SHALL latch the owner, the length and the command byte at that grant.
REQ-005 Priority SHALL be: (1) req_audio while audio_urgent=1; (2) round-robin against last_owner; (3) the sole requester.
REQ-006 last_owner SHALL update only on a completed transfer (DONE), not on an abort.
REQ-007 In SEND_CMD, cmd_valid SHALL be 1 and chip_select SHALL be 0; when cmd_ready=1 the FSM SHALL go to WAIT_HDR and cmd_valid SHALL drop.
REQ-008 In WAIT_HDR, any rx byte that does not equal the latched command SHALL be discarded.
REQ-009 In WAIT_HDR, a matching byte SHALL move the FSM to STREAM, or directly to DONE if the latched length is 0.
REQ-010 In WAIT_HDR, the timeout counter SHALL count ticks; when it reaches HDR_TIMEOUT-1 the FSM SHALL pulse hdr_err and go to GAP.
REQ-011 In STREAM, each rx_valid SHALL produce exactly one wr_en of the owner, with wr_data=rx_data, one CLK_40 cycle after the strobe, and SHALL decrement the remaining count.
REQ-012 In STREAM, the strobe on which the remaining count becomes 0 SHALL move the FSM to DONE.
REQ-013 In DONE, xfer_done SHALL pulse for one CLK_40 cycle and the FSM SHALL go to GAP.
REQ-014 In GAP, chip_select SHALL be 1 for exactly one tick before IDLE; no grant SHALL be issued from GAP.
REQ-015 grant_* SHALL be held from grant through GAP and SHALL never both be 1.
REQ-016 Requests dropping mid-transfer SHALL be ignored; len_* changes after grant SHALL be ignored.
REQ-017 The remaining-byte counter SHALL be LEN_W bits and SHALL never wrap below 0.
REQ-018 Bytes received outside WAIT_HDR and STREAM SHALL be discarded.
REQ-019 If SPI_clk_en=0, all outputs other than the one-cycle pulses SHALL hold.

Reset
REQ-020 While reset=1, the state SHALL be IDLE asynchronously.
REQ-021 On reset: chip_select=1, cmd_valid=0, cmd_byte=0, grant_*=0, wr_en_*=0, wr_data=0, xfer_done=0, hdr_err=0, busy=0, counters=0, last_owner=audio (so video wins the first tie).
REQ-022 Reset mid-transfer SHALL abort immediately, with no further writes and no xfer_done pulse.

Verification
REQ-023 Video only, len_video=3 -> cmd_byte=FA, CS low; stream 00,FA,11,22,33 -> 00 is dropped, three wr_en_video writing 11,22,33, one xfer_done, then one CS-high GAP tick.
REQ-024 Both requesting, urgent=0, two back-to-back transfers -> order is video then audio; both requesting with urgent=1 -> audio wins regardless of last_owner.
REQ-025 HDR_TIMEOUT=8, slave returns only 00 -> hdr_err pulses after 8 ticks, no writes, and the same requester is re-granted next.
REQ-026 len_audio=0 -> header AA leads straight to xfer_done with zero writes.
REQ-027 Reset asserted after the 2nd of 4 bytes -> outputs go to reset values within the same cycle and no write follows.
REQ-028 SPI_clk_en held low for 5 cycles during STREAM -> state and outputs hold and the byte count is unchanged.
